pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 17 +
 rtl/pc_target_check.sv | 22 ++
 rtl/pc_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the PC sequencer.
// Optional single-step support is enabled by defining PC_SEQ_SINGLE_STEP_EN.
package pc_seq_pkg;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] DEF_EXC_VECTOR = 32'h0000_0080;
    localparam logic [INSTR_W-1:0] INSTR_BYTES    = 32'd4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_HALT     = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pc_target_check.sv
// Combinational alignment and range check for a fetch address.
// Flags word misalignment or an address at/after the end of instruction memory.
module pc_target_check
    import pc_seq_pkg::*;
#(
    parameter int IMEM_WORDS = 256
) (
    input  logic [INSTR_W-1:0] addr,
    output logic               fault
);

    // One extra bit so the limit is exact even for a full 4 GiB space.
    localparam logic [INSTR_W:0] LIMIT = (INSTR_W+1)'(IMEM_WORDS) << 2;

    logic misaligned;
    logic out_of_range;

    assign misaligned   = (addr[1:0] != 2'b00);
    assign out_of_range = ({1'b0, addr} >= LIMIT);
    assign fault        = misaligned || out_of_range;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: RUN / REDIRECT / HALT with fault redirect.
// Define PC_SEQ_SINGLE_STEP_EN to add the step input for HALT single-step.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [INSTR_W-1:0] EXC_VECTOR = DEF_EXC_VECTOR,
    parameter int                 IMEM_WORDS = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [INSTR_W-1:0] br_target,
    input  logic               jmp,
    input  logic [INSTR_W-1:0] jmp_target,
    input  logic               exc_req,
    input  logic               halt_req,
    input  logic               resume,
`ifdef PC_SEQ_SINGLE_STEP_EN
    input  logic               step,
`endif
    output logic [INSTR_W-1:0] pc,
    output logic               pc_valid,
    output logic               flush,
    output logic               fetch_fault,
    output logic               halted
);

    seq_state_t         state_q, state_d;
    logic [INSTR_W-1:0] pc_q, pc_d;
    logic               flush_q, flush_d;
    logic               fault_q, fault_d;

    logic               redir;
    logic [INSTR_W-1:0] tgt;
    logic [INSTR_W-1:0] pc_seq;
    logic               tgt_bad;
    logic               seq_bad;
    logic               step_req;

    assign redir  = br_taken || jmp;
    assign tgt    = br_taken ? br_target : jmp_target;
    assign pc_seq = pc_q + INSTR_BYTES;

`ifdef PC_SEQ_SINGLE_STEP_EN
    assign step_req = step;
`else
    assign step_req = 1'b0;
`endif

    pc_target_check #(
        .IMEM_WORDS(IMEM_WORDS)
    ) u_tgt_chk (
        .addr (tgt),
        .fault(tgt_bad)
    );

    pc_target_check #(
        .IMEM_WORDS(IMEM_WORDS)
    ) u_seq_chk (
        .addr (pc_seq),
        .fault(seq_bad)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = 1'b0;
        fault_d = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (exc_req) begin
                    pc_d    = EXC_VECTOR;
                    flush_d = 1'b1;
                    state_d = ST_REDIRECT;
                end else if ((redir && tgt_bad) ||
                             (!redir && !halt_req && !stall && seq_bad)) begin
                    pc_d    = EXC_VECTOR;
                    flush_d = 1'b1;
                    fault_d = 1'b1;
                    state_d = ST_REDIRECT;
                end else if (redir) begin
                    pc_d    = tgt;
                    flush_d = 1'b1;
                    state_d = ST_REDIRECT;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end else if (!stall) begin
                    pc_d = pc_seq;
                end
            end
            // Bubble cycle: always moves on, stall has no effect here.
            ST_REDIRECT: begin
                state_d = ST_RUN;
                if (exc_req || seq_bad) begin
                    pc_d    = EXC_VECTOR;
                    flush_d = 1'b1;
                    fault_d = !exc_req;
                    state_d = ST_REDIRECT;
                end else begin
                    pc_d = pc_seq;
                end
            end
            ST_HALT: begin
                if (exc_req) begin
                    pc_d    = EXC_VECTOR;
                    flush_d = 1'b1;
                    state_d = ST_REDIRECT;
                end else if (resume) begin
                    state_d = ST_RUN;
                end else if (step_req && seq_bad) begin
                    pc_d    = EXC_VECTOR;
                    flush_d = 1'b1;
                    fault_d = 1'b1;
                    state_d = ST_REDIRECT;
                end else if (step_req) begin
                    pc_d = pc_seq;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            fault_q <= fault_d;
        end
    end

    assign pc          = pc_q;
    assign flush       = flush_q;
    assign fetch_fault = fault_q;
    assign halted      = (state_q == ST_HALT);
    assign pc_valid    = (state_q == ST_RUN) ||
                         ((state_q == ST_HALT) && step_req &&
                          !resume && !exc_req);

endmodule
